// File: rtl/slave_vldrdy.sv
// slave_vldrdy: valid/ready consumer stage with an M-entry FIFO.
// Words accepted on the src port are buffered and re-presented on the
// rd drain port in strict FIFO order. src_rdy and rd_val depend only on
// registered state, cfg_en and rst, so there is no combinational path
// from src_val or rd_rdy to either handshake output.
// Optional build macro SLAVE_VLDRDY_CHECK_EN adds a src-side protocol
// monitor driving the sticky proto_err flag; without it proto_err is 0.
module slave_vldrdy #(
  parameter int DWIDTH = 8,
  parameter int M      = 32,
  parameter int CWIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_en,
  input  logic                 src_val,
  output logic                 src_rdy,
  input  logic [DWIDTH-1:0]    src_data,
  output logic                 rd_val,
  input  logic                 rd_rdy,
  output logic [DWIDTH-1:0]    rd_data,
  output logic [$clog2(M):0]   level,
  output logic [CWIDTH-1:0]    rx_cnt,
  output logic                 proto_err
);

  localparam int AW = $clog2(M);
  localparam logic [AW:0]       PTR_ONE = 1;
  localparam logic [CWIDTH-1:0] CNT_ONE = 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]       wptr;
  logic [AW:0]       rptr;
  logic [DWIDTH-1:0] mem [M];

  logic empty;
  logic full;
  logic push;
  logic pop;

  // Status and handshake decode; rst forces both handshakes low in the reset cycle.
  always_comb begin
    empty   = (wptr == rptr);
    full    = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    src_rdy = !rst && cfg_en && !full;
    rd_val  = !rst && cfg_en && !empty;
    push    = src_val && src_rdy;
    pop     = rd_val && rd_rdy;
    rd_data = mem[rptr[AW-1:0]];
    level   = wptr - rptr;
  end

  // Pointer and accepted-word counter update.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      wptr   <= '0;
      rptr   <= '0;
      rx_cnt <= '0;
    end else begin
      if (push) begin
        wptr   <= wptr + PTR_ONE;
        rx_cnt <= rx_cnt + CNT_ONE;
      end
      if (pop) begin
        rptr <= rptr + PTR_ONE;
      end
    end
  end

  // Storage write; read side is the combinational mem[rptr] above.
  always_ff @(posedge clk) begin
    // NOTE: the array is deliberately left out of reset; stale contents are
    // never visible because rd_val gates them and reset empties the pointers.
    if (push) begin
      mem[wptr[AW-1:0]] <= src_data;
    end
  end

`ifdef SLAVE_VLDRDY_CHECK_EN
  logic              src_val_q;
  logic              src_rdy_q;
  logic [DWIDTH-1:0] src_data_q;
  logic              stall_q;
  logic              violation;

  // A word stalled last cycle must stay valid with unchanged data.
  always_comb begin
    stall_q   = src_val_q && !src_rdy_q;
    violation = cfg_en && stall_q && (!src_val || (src_data != src_data_q));
  end

  // Handshake history and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      src_val_q  <= 1'b0;
      src_rdy_q  <= 1'b0;
      src_data_q <= '0;
      proto_err  <= 1'b0;
    end else begin
      src_val_q  <= src_val;
      src_rdy_q  <= src_rdy;
      src_data_q <= src_data;
      if (violation) begin
        proto_err <= 1'b1;
      end
    end
  end
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_slave_vldrdy.sv
// tb_slave_vldrdy: directed and randomized stimulus for slave_vldrdy,
// checked every cycle against a queue-based FIFO model.
module tb_slave_vldrdy;

  localparam int DWIDTH = 8;
  localparam int M      = 32;
  localparam int CWIDTH = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic                cfg_en;
  logic                src_val;
  logic                src_rdy;
  logic [DWIDTH-1:0]   src_data;
  logic                rd_val;
  logic                rd_rdy;
  logic [DWIDTH-1:0]   rd_data;
  logic [$clog2(M):0]  level;
  logic [CWIDTH-1:0]   rx_cnt;
  logic                proto_err;

  slave_vldrdy #(.DWIDTH(DWIDTH), .M(M), .CWIDTH(CWIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_en    (cfg_en),
    .src_val   (src_val),
    .src_rdy   (src_rdy),
    .src_data  (src_data),
    .rd_val    (rd_val),
    .rd_rdy    (rd_rdy),
    .rd_data   (rd_data),
    .level     (level),
    .rx_cnt    (rx_cnt),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  // Reference model state.
  logic [DWIDTH-1:0] q[$];
  int unsigned       cnt;
  logic              err;
  logic              prev_val;
  logic              prev_rdy;
  logic [DWIDTH-1:0] prev_data;
  logic              last_push;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_src_rdy();
    return !rst && cfg_en && (q.size() < M);
  endfunction

  function automatic logic exp_rd_val();
    return !rst && cfg_en && (q.size() > 0);
  endfunction

  function automatic logic exp_proto_err();
`ifdef SLAVE_VLDRDY_CHECK_EN
    return err;
`else
    return 1'b0;
`endif
  endfunction

  // Compare every observable output with the model.
  task automatic check_all(input string tag);
    #1;
    check({tag, ".src_rdy"}, 32'(src_rdy), 32'(exp_src_rdy()));
    check({tag, ".rd_val"},  32'(rd_val),  32'(exp_rd_val()));
    check({tag, ".level"},   32'(level),   32'(q.size()));
    check({tag, ".rx_cnt"},  32'(rx_cnt),  32'(cnt % (1 << CWIDTH)));
    check({tag, ".proto_err"}, 32'(proto_err), 32'(exp_proto_err()));
    if (exp_rd_val()) check({tag, ".rd_data"}, 32'(rd_data), 32'(q[0]));
  endtask

  // Advance one clock and apply the handshake rules to the model.
  task automatic cyc();
    logic do_push, do_pop, viol;
    logic [DWIDTH-1:0] d;
    do_push = src_val && exp_src_rdy();
    do_pop  = exp_rd_val() && rd_rdy;
    viol    = cfg_en && prev_val && !prev_rdy && (!src_val || (src_data != prev_data));
    d       = src_data;
    @(posedge clk);
    if (rst) begin
      q.delete();
      cnt = 0; err = 1'b0;
      prev_val = 1'b0; prev_rdy = 1'b0; prev_data = '0;
      last_push = 1'b0;
    end else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        q.push_back(d);
        cnt++;
      end
      if (viol) err = 1'b1;
      prev_val  = src_val;
      prev_rdy  = !full_before(do_push, do_pop);
      prev_data = d;
      last_push = do_push;
    end
    @(negedge clk);
  endtask

  // Handshake ready as it was before the edge (reconstructed from the post-edge queue).
  function automatic logic full_before(input logic pushed, input logic popped);
    int sz = q.size() - int'(pushed) + int'(popped);
    return cfg_en && (sz < M);
  endfunction

  task automatic step(input string tag);
    check_all(tag);
    cyc();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step("reset");
    rst = 1'b0;
  endtask

  task automatic push_words(input int n, input logic [DWIDTH-1:0] base, input string tag);
    rd_rdy = 1'b0;
    for (int i = 0; i < n; i++) begin
      src_val  = 1'b1;
      src_data = base + DWIDTH'(i);
      step(tag);
    end
    src_val = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_en = 1'b0; src_val = 1'b0; src_data = '0; rd_rdy = 1'b0;
    q.delete(); cnt = 0; err = 1'b0;
    prev_val = 1'b0; prev_rdy = 1'b0; prev_data = '0; last_push = 1'b0;
    @(negedge clk);
    cyc();
    do_reset();
    cfg_en = 1'b1;

    // Basic push then drain.
    push_words(5, 8'h01, "t1_push");
    check_all("t1_loaded");
    check("t1_level5", 32'(level), 32'd5);
    check("t1_head", 32'(rd_data), 32'h01);
    rd_rdy = 1'b1;
    for (int i = 0; i < 6; i++) step("t1_drain");
    check("t1_empty", 32'(rd_val), 32'd0);

    // Fill to capacity, pop one, push a 33rd word.
    push_words(M, 8'hA0, "t2_fill");
    check("t2_full_rdy", 32'(src_rdy), 32'd0);
    check("t2_level32", 32'(level), 32'(M));
    src_val = 1'b1; src_data = 8'hC0; rd_rdy = 1'b1;
    step("t2_pop_full");
    rd_rdy = 1'b0;
    check("t2_rdy_back", 32'(src_rdy), 32'd1);
    step("t2_push33");
    src_val = 1'b0;
    check("t2_level_again", 32'(level), 32'(M));
    rd_rdy = 1'b1;
    for (int i = 0; i < M + 1; i++) step("t2_drain");

    // Continuous streaming with wrap-around.
    do_reset();
    src_val = 1'b1; rd_rdy = 1'b1;
    for (int i = 0; i < 100; i++) begin
      src_data = DWIDTH'(i);
      step("t3_stream");
    end
    src_val = 1'b0;
    check_all("t3_end");
    check("t3_rx_cnt", 32'(rx_cnt), 32'd100);
    step("t3_flush");

    // Disable holds state; re-enable resumes in order.
    push_words(3, 8'h30, "t4_load");
    cfg_en = 1'b0; rd_rdy = 1'b1; src_val = 1'b1; src_data = 8'h77;
    for (int i = 0; i < 4; i++) step("t4_off");
    src_val = 1'b0; cfg_en = 1'b1;
    for (int i = 0; i < 4; i++) step("t4_resume");

    // Reset mid-operation.
    push_words(10, 8'h40, "t5_load");
    do_reset();
    check_all("t5_after_rst");
    src_val = 1'b1; src_data = 8'h5A;
    step("t5_push");
    src_val = 1'b0;
    check("t5_data", 32'(rd_data), 32'h5A);
    rd_rdy = 1'b1;
    step("t5_pop");

    // Protocol violation while full: data changes under stall.
    do_reset();
    push_words(M, 8'h00, "t6_fill");
    src_val = 1'b1; src_data = 8'h11;
    step("t6_stall");
    src_data = 8'h22;
    step("t6_change");
    src_val = 1'b0;
    for (int i = 0; i < 3; i++) step("t6_sticky");
    do_reset();
    check_all("t6_cleared");

    // Randomized traffic obeying the src protocol.
    for (int i = 0; i < 600; i++) begin
      cfg_en = ($urandom_range(0, 15) != 0);
      rd_rdy = $urandom_range(0, 1) != 0;
      if (!(src_val && !last_push)) begin
        src_val  = ($urandom_range(0, 2) != 0);
        src_data = DWIDTH'($urandom);
      end
      step("rand");
    end
    check_all("rand_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/slave_vldrdy.md
Name: slave_vldrdy

Overview:
- Downstream consumer stage for the 8-bit valid/ready master stream.
- Accepts words on the src side, buffers them in an M-entry FIFO, and re-presents them on a valid/ready drain port.
- Exposes fill level and a running count of accepted words.
- Applies real backpressure (src_rdy) when full or disabled.

Parameters:
DWIDTH, 8, data width of the stream in bits
M, 32, FIFO depth in words; power of two, >= 2
CWIDTH, 16, width of the accepted-word counter

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous reset, active high
cfg_en  input  1  enable, active high
src_val  input  1  upstream valid
src_rdy  output  1  upstream ready
src_data  input  DWIDTH  upstream data, steady while src_val high and src_rdy low
rd_val  output  1  drain valid
rd_rdy  input  1  drain ready
rd_data  output  DWIDTH  drain data
level  output  $clog2(M)+1  current number of stored words, 0..M
rx_cnt  output  CWIDTH  words accepted since reset, wraps modulo 2^CWIDTH
proto_err  output  1  sticky protocol-violation flag (see Optional Feature)

Behaviour:
- Reset (rst high at a rising edge) clears:
  - write/read pointers, level, rx_cnt and proto_err to 0;
  - rd_val = 0, src_rdy = 0 in the reset cycle.
  - Memory contents are not cleared; rd_data is don't-care while rd_val = 0.
- Pointers are $clog2(M)+1 bits wide (wrap bit included).
  - empty = pointers equal.
  - full = index bits equal and wrap bits differ.
  - Pointers wrap naturally from M-1 to 0.
- src_rdy = cfg_en & !full. It is combinational from registered state only; there is no path from src_val or rd_rdy.
- push = src_val & src_rdy. On push, mem[wptr] <= src_data, wptr++ and rx_cnt++ (wrapping from 2^CWIDTH-1 to 0).
- rd_val = cfg_en & !empty. rd_data = mem[rptr], read combinationally; it is stable while rd_val is high and no pop occurs.
- pop = rd_val & rd_rdy. On pop, rptr++.
- Latency:
  - a word pushed at edge N is visible on rd_val/rd_data after edge N (one cycle);
  - there is no same-cycle fall-through when empty.
- Simultaneous push and pop: both are performed and level is unchanged.
  - When full, push cannot occur (src_rdy = 0), even if a pop happens in the same cycle.
  - src_rdy rises the cycle after the pop.
- level = wptr - rptr, computed modulo 2^($clog2(M)+1). It is updated at each edge: +1 on push only, -1 on pop only.
- cfg_en low:
  - src_rdy = 0 and rd_val = 0;
  - pointers, contents, level and rx_cnt are held.
  - On re-enable, the buffered data resumes in order.
- Reset mid-operation: all buffered words are discarded; the next accepted word lands at index 0.
- Order is strictly FIFO; no words are dropped or duplicated.

Optional Feature:
- Macro: SLAVE_VLDRDY_CHECK_EN
- Defined: protocol monitor on the src side. It registers src_val, src_data and src_rdy each cycle. proto_err sets (sticky until rst) in the cycle after either of these violations:
  - the previous cycle had src_val = 1 and src_rdy = 0, and now src_val = 0 (valid withdrawn);
  - the previous cycle had src_val = 1 and src_rdy = 0, and now src_data differs (data changed).
  - Violations while cfg_en = 0 are ignored, because the protocol may be broken on disable.
- Undefined: proto_err is tied to 0 and no monitor logic is synthesised.

Test Plan:
- Reset, cfg_en=1, push 0x01..0x05 with rd_rdy=0 -> level=5, rx_cnt=5, rd_val=1, rd_data=0x01; then rd_rdy=1 for 5 cycles -> rd_data sequence 0x01..0x05, then rd_val=0, level=0.
- Push 32 words 0xA0+i with rd_rdy=0 -> src_rdy=0 after the 32nd push, level=32; one pop -> src_rdy=1 the next cycle; a 33rd push is accepted and level returns to 32.
- src_val=1 and rd_rdy=1 continuously for 100 cycles with incrementing data -> level stays at 1 after the first cycle; output equals input delayed by 1 cycle; rx_cnt=100; pointers wrap 3 times.
- Load 3 words, drop cfg_en for 4 cycles -> src_rdy=0, rd_val=0, level=3 held; raise cfg_en -> the 3 words drain in order.
- Load 10 words, assert rst for 1 cycle -> level=0, rx_cnt=0, rd_val=0; next push of 0x5A appears as rd_data=0x5A.
- With SLAVE_VLDRDY_CHECK_EN: fill the FIFO, hold src_val=1 and change src_data from 0x11 to 0x22 -> proto_err=1 the next cycle and stays 1 until rst; without the macro -> proto_err stays 0.
